// File: rtl/masked_present_inv_sbox_layer_pkg.sv
// Shared constants, state encoding and reference table
// for the masked inverse PRESENT S-box layer.
package masked_present_inv_sbox_layer_pkg;

  localparam int NIBBLES  = 16;
  localparam int SBOX_LAT = 3;
  localparam int RND_W    = 4;

  // Unmasked Sinv, nibble i of the constant is Sinv(i)
  localparam logic [63:0] SINV_LUT = 64'hA970_364B_D21C_8FE5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/masked_present_inv_sbox_layer_sbox.sv
// Two-share DOM inverse PRESENT S-box, three register stages,
// four DOM-AND gadgets (A,B then C,D), one fresh bit each.
module masked_present_inv_sbox
  import masked_present_inv_sbox_layer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [3:0]       x0_i,
  input  logic [3:0]       x1_i,
  input  logic [RND_W-1:0] rnd_i,
  output logic             out_valid_o,
  output logic [3:0]       y0_o,
  output logic [3:0]       y1_o
);

  // {d1&e1, d1&e0^r, d0&e1^r, d0&e0}, all registered
  function automatic logic [3:0] dom_terms(
    input logic p0, input logic q0,
    input logic p1, input logic q1,
    input logic r
  );
    return {p1 & q1, (p1 & q0) ^ r,
            (p0 & q1) ^ r, p0 & q0};
  endfunction

  // Share-local output map, k is the constant
  // carried by share 0 only
  function automatic logic [3:0] y_map(
    input logic [3:0] xs,
    input logic ta, input logic tb,
    input logic tc, input logic td,
    input logic k
  );
    logic [3:0] ys;
    ys[0] = tb ^ xs[0] ^ xs[2] ^ k;
    ys[1] = tc ^ td ^ tb ^ xs[0] ^ xs[1] ^ xs[3];
    ys[2] = tc ^ td ^ tb ^ ta ^ xs[3] ^ k;
    ys[3] = tc ^ xs[0] ^ xs[1] ^ xs[2] ^ xs[3];
    return ys;
  endfunction

  logic [SBOX_LAT-1:0] v_q;
  logic [3:0] ga_q, gb_q, gc_q, gd_q;
  logic [3:0] x0_s1_q, x1_s1_q;
  logic [3:0] x0_s2_q, x1_s2_q;
  logic [1:0] r_s1_q;
  logic [1:0] a_s2_q, b_s2_q;
  logic [3:0] y0_q, y1_q;

  logic a0, a1, b0, b1;
  logic ma0, ma1, mb0, mb1;
  logic ca0, ca1, cb0, cb1;
  logic da0, da1, db0, db1;
  logic mc0, mc1, md0, md1;

  // A = (x0^x2)(x1^x3), B = x1 x3
  assign a0 = x0_i[0] ^ x0_i[2];
  assign b0 = x0_i[1] ^ x0_i[3];
  assign a1 = x1_i[0] ^ x1_i[2];
  assign b1 = x1_i[1] ^ x1_i[3];

  assign ma0 = ga_q[0] ^ ga_q[1];
  assign ma1 = ga_q[3] ^ ga_q[2];
  assign mb0 = gb_q[0] ^ gb_q[1];
  assign mb1 = gb_q[3] ^ gb_q[2];

  // C = (A^x3) x0, D = (B^x1^x2)(x0^x3)
  assign ca0 = ma0 ^ x0_s1_q[3];
  assign ca1 = ma1 ^ x1_s1_q[3];
  assign cb0 = x0_s1_q[0];
  assign cb1 = x1_s1_q[0];
  assign da0 = mb0 ^ x0_s1_q[1] ^ x0_s1_q[2];
  assign da1 = mb1 ^ x1_s1_q[1] ^ x1_s1_q[2];
  assign db0 = x0_s1_q[0] ^ x0_s1_q[3];
  assign db1 = x1_s1_q[0] ^ x1_s1_q[3];

  assign mc0 = gc_q[0] ^ gc_q[1];
  assign mc1 = gc_q[3] ^ gc_q[2];
  assign md0 = gd_q[0] ^ gd_q[1];
  assign md1 = gd_q[3] ^ gd_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[SBOX_LAT-2:0], in_valid_i};
    end
  end

  always_ff @(posedge clk) begin
    ga_q    <= dom_terms(a0, b0, a1, b1, rnd_i[0]);
    gb_q    <= dom_terms(x0_i[1], x0_i[3],
                         x1_i[1], x1_i[3], rnd_i[1]);
    x0_s1_q <= x0_i;
    x1_s1_q <= x1_i;
    r_s1_q  <= rnd_i[3:2];
    gc_q    <= dom_terms(ca0, cb0, ca1, cb1, r_s1_q[0]);
    gd_q    <= dom_terms(da0, db0, da1, db1, r_s1_q[1]);
    a_s2_q  <= {ma1, ma0};
    b_s2_q  <= {mb1, mb0};
    x0_s2_q <= x0_s1_q;
    x1_s2_q <= x1_s1_q;
    y0_q    <= y_map(x0_s2_q, a_s2_q[0], b_s2_q[0],
                     mc0, md0, 1'b1);
    y1_q    <= y_map(x1_s2_q, a_s2_q[1], b_s2_q[1],
                     mc1, md1, 1'b0);
  end

  assign out_valid_o = v_q[SBOX_LAT-1];
  assign y0_o        = y0_q;
  assign y1_o        = y1_q;

endmodule

// File: rtl/masked_present_inv_sbox_layer.sv
// Masked inverse PRESENT S-box layer: serialises 16 nibbles
// through one shared pipelined masked S-box.
module masked_present_inv_sbox_layer
  import masked_present_inv_sbox_layer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_s0,
  input  logic [63:0]      in_s1,
  input  logic [RND_W-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_s0,
  output logic [63:0]      out_s1,
  output logic             busy
);

  state_e      state_q, state_d;
  logic [4:0]  issue_q, issue_d;
  logic [4:0]  coll_q, coll_d;
  logic [63:0] ish0_q, ish0_d, ish1_q, ish1_d;
  logic [63:0] osh0_q, osh0_d, osh1_q, osh1_d;

  logic       issue;
  logic       sb_valid;
  logic [3:0] sb_y0, sb_y1;

  assign issue = (state_q == ST_RUN) && !issue_q[4];

  masked_present_inv_sbox u_sbox (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (issue),
    .x0_i        (ish0_q[3:0]),
    .x1_i        (ish1_q[3:0]),
    .rnd_i       (rnd),
    .out_valid_o (sb_valid),
    .y0_o        (sb_y0),
    .y1_o        (sb_y1)
  );

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    coll_d  = coll_q;
    ish0_d  = ish0_q;
    ish1_d  = ish1_q;
    osh0_d  = osh0_q;
    osh1_d  = osh1_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (in_valid) begin
          ish0_d  = in_s0;
          ish1_d  = in_s1;
          issue_d = '0;
          coll_d  = '0;
          state_d = ST_RUN;
        end
      end
      state_q == ST_RUN: begin
        if (issue) begin
          ish0_d  = {4'h0, ish0_q[63:4]};
          ish1_d  = {4'h0, ish1_q[63:4]};
          issue_d = issue_q + 5'd1;
        end
        // nibble 0 returns first and ends up in bits [3:0]
        if (sb_valid) begin
          osh0_d = {sb_y0, osh0_q[63:4]};
          osh1_d = {sb_y1, osh1_q[63:4]};
          coll_d = coll_q + 5'd1;
          if (coll_q == 5'(NIBBLES - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      state_q == ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
      coll_q  <= '0;
      ish0_q  <= '0;
      ish1_q  <= '0;
      osh0_q  <= '0;
      osh1_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      coll_q  <= coll_d;
      ish0_q  <= ish0_d;
      ish1_q  <= ish1_d;
      osh0_q  <= osh0_d;
      osh1_q  <= osh1_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_s0    = osh0_q;
  assign out_s1    = osh1_q;

endmodule

// File: tb/tb_masked_present_inv_sbox_layer.sv
// Directed and random bench for the masked inverse S-box
// layer with a result scoreboard.
module tb_masked_present_inv_sbox_layer;
  import masked_present_inv_sbox_layer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_s0, in_s1;
  logic [RND_W-1:0] rnd;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_s0, out_s1;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  masked_present_inv_sbox_layer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s0     (in_s0),
    .in_s1     (in_s1),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .busy      (busy)
  );

  function automatic logic [63:0] sinv64(input logic [63:0] x);
    logic [63:0] lut;
    logic [63:0] r;
    int idx;
    lut = SINV_LUT;
    r = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      idx = int'(x[4*i +: 4]);
      r[4*i +: 4] = lut[4*idx +: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rnd = RND_W'($urandom);
  endtask

  // One transaction; stall>0 holds out_ready low in DONE
  task automatic do_txn(input logic [63:0] s0,
                        input logic [63:0] s1,
                        input int stall);
    int n;
    logic [63:0] e;
    out_ready = (stall == 0);
    in_s0 = s0;
    in_s1 = s1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    sb_q.push_back(sinv64(s0 ^ s1));
    tick();
    in_valid = 1'b0;
    in_s0 = rand64();
    in_s1 = rand64();
    chk("busy_run", 64'(busy), 64'd1);
    chk("in_ready_run", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd19);
    chk("out_valid", 64'(out_valid), 64'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk("result", out_s0 ^ out_s1, e);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1;
        in_s0 = rand64();
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold", out_s0 ^ out_s1, e);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_in_ready_after", 64'(in_ready), 64'd1);
      chk("bp_valid_after", 64'(out_valid), 64'd0);
      chk("bp_keep", out_s0 ^ out_s1, e);
      tick();
      chk("bp_idle", 64'(busy), 64'd0);
    end else begin
      tick();
    end
  endtask

  initial begin
    logic [63:0] m;
    logic [63:0] e;
    logic [63:0] b0 [3];
    logic [63:0] b1 [3];
    int seen, k, got, cyc, last_out;
    bit ohs, ihs, adv;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_s0 = '0;
    in_s1 = '0;
    rnd = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_s0", out_s0, 64'd0);
    chk("rst_out_s1", out_s1, 64'd0);
    rst = 1'b0;
    tick();

    do_txn(64'h0123_4567_89AB_CDEF, 64'd0, 0);
    chk("known_vec", out_s0 ^ out_s1,
        64'h5EF8_C12D_B463_079A);
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      m = rand64();
      do_txn(64'h7777_7777_7777_7777 ^ m, m, 0);
      chk("all_sevens", out_s0 ^ out_s1,
          64'hDDDD_DDDD_DDDD_DDDD);
    end

    for (int i = 0; i < 1000; i++) begin
      m = rand64();
      do_txn(rand64() ^ m, m, 0);
    end

    do_txn(rand64(), rand64(), 5);

    // Reset 7 cycles into a transaction
    in_s0 = rand64();
    in_s1 = rand64();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", out_s0 | out_s1, 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_valid_after_rst", 64'(seen), 64'd0);
    do_txn(64'hFEDC_BA98_7654_3210, rand64(), 0);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      b1[i] = rand64();
      b0[i] = rand64();
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_s0 = b0[0];
    in_s1 = b1[0];
    k = 0;
    got = 0;
    cyc = 0;
    last_out = -10;
    while (got < 3 && cyc < 200) begin
      ohs = out_valid && out_ready;
      ihs = in_valid && in_ready;
      adv = 1'b0;
      if (ohs) begin
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("b2b_result", out_s0 ^ out_s1, e);
        got++;
        last_out = cyc;
      end
      if (ihs) begin
        if (k > 0) chk("b2b_gap", 64'(cyc - last_out), 64'd1);
        sb_q.push_back(sinv64(b0[k] ^ b1[k]));
        k++;
        adv = 1'b1;
      end
      tick();
      cyc++;
      if (adv) begin
        if (k < 3) begin
          in_s0 = b0[k];
          in_s1 = b1[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 64'(got), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/masked_present_inv_sbox_layer.md
Name: masked_present_inv_sbox_layer

Overview:
- First-order DOM-masked (2-share) inverse PRESENT substitution layer for the decryption datapath.
- Accepts a 64-bit state as two Boolean shares and applies S^-1 to all 16 nibbles.
- Uses one shared, pipelined masked inverse S-box, fed one nibble per cycle and sequenced by an FSM.
- Has valid/ready handshakes on both input and output. It sits between the masked key-add and inverse pLayer stages of the masked PRESENT decryption round.

Parameters:
NIBBLES, 16, number of 4-bit nibbles in the state
SBOX_LAT, 3, fixed register latency of the masked inverse S-box sub-module
RND_W, 4, fresh random bits consumed per nibble issue (one per DOM-AND gadget)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input state shares valid
in_ready  out  1  block can accept a state
in_s0  in  64  state share 0, nibble i = bits [4i+3:4i]
in_s1  in  64  state share 1
rnd  in  RND_W  fresh randomness, sampled every issue cycle
out_valid  out  1  output shares valid
out_ready  in  1  downstream accepts output
out_s0  out  64  result share 0
out_s1  out  64  result share 1
busy  out  1  high in RUN or DONE

Behaviour:
- Unmasked function per nibble: out_s0^out_s1 = Sinv(in_s0^in_s1), Sinv = {5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A}.
- Reset (sync, active-high, overrides everything):
  - FSM goes to IDLE; counters cleared.
  - in_ready=1 (IDLE), out_valid=0, busy=0, out_s0=out_s1=0.
  - The pipeline is flushed: its valid bits are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, both shares are captured into shift registers and the FSM goes to RUN with issue_cnt=0 and coll_cnt=0.
- RUN:
  - in_ready=0.
  - Each cycle while issue_cnt<NIBBLES: nibble issue_cnt of each share and rnd go into the sub-module; issue_cnt increments.
  - The sub-module returns each nibble exactly SBOX_LAT cycles after issue. Results are shifted into the output shift registers, nibble 0 first; coll_cnt increments.
  - When coll_cnt reaches NIBBLES-1 and that result is captured, the FSM goes to DONE.
- Latency: out_valid rises exactly NIBBLES+SBOX_LAT cycles after the input handshake edge (19 with defaults).
- DONE:
  - out_valid=1; out_s0/out_s1 are held stable until out_ready.
  - On out_valid&&out_ready the FSM goes to IDLE next cycle; out_valid=0 and in_ready=1 that next cycle.
  - Output shares keep their value after the handshake until overwritten.
- No overlap between transactions: in_valid is ignored outside IDLE. in_s0/in_s1 need not be held after the handshake.
- Sub-module rules:
  - Shares are never combined outside DOM gadgets; every DOM cross-domain term is registered before recombination.
  - Each rnd bit is used in exactly one gadget. Randomness freshness is the source's responsibility and is not checked.
  - Linear share paths are register-balanced to SBOX_LAT so share 0 and share 1 data of different nibbles never meet in logic.
- Sub-module validity: a valid bit travels alongside each nibble; collection uses this bit, not a cycle count.
- Reset mid-RUN or mid-DONE: the transaction is discarded; no out_valid pulse follows.
- All widths are exact; no arithmetic beyond 5-bit counters.

Decomposition:
- Shared package: NIBBLES, SBOX_LAT, RND_W constants; the unmasked Sinv lookup constant (testbench reference only); an FSM state enum.
- Sub-module masked_present_inv_sbox:
  - 2-share DOM inverse S-box with in_valid/out_valid pipeline tag.
  - Fixed SBOX_LAT latency, RND_W random inputs, no handshake stall.
  - The top-level holds the FSM, shift registers and counters.

Test Plan:
- Reset: assert rst 2 cycles -> in_ready=1, out_valid=0, busy=0, out_s0=out_s1=0.
- in_s0=0x0123456789ABCDEF, in_s1=0, out_ready=1 -> out_valid exactly 19 cycles after handshake, out_s0^out_s1=0x5EF8C12DB463079A.
- Random mask M, in_s1=M, in_s0=0x7777777777777777^M, random rnd -> recombined output 0xDDDDDDDDDDDDDDDD. Check over 1000 random states/masks against the Sinv model.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> in_ready=1 next cycle.
- rst asserted 7 cycles after handshake -> IDLE next cycle, no out_valid. Next transaction returns the correct result.
- Back-to-back: in_valid held high with 3 queued states -> each result correct, each accepted exactly 1 cycle after the previous output handshake.
